// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stopwatch_ctrl_if : raw button/switch inputs and counter control strobes
// Rev 1.0
// ----------------------------------------------------------------------------
interface stopwatch_ctrl_if;
  logic btn_pause;
  logic btn_clr;
  logic sw_adj;
  logic sw_sel;
  logic cnt_en;
  logic cnt_clr;
  logic adj_sec;
  logic adj_min;
  logic paused;
  logic blink;

  modport master (
    input  btn_pause, btn_clr, sw_adj, sw_sel,
    output cnt_en, cnt_clr, adj_sec, adj_min, paused, blink
  );

  modport slave (
    output btn_pause, btn_clr, sw_adj, sw_sel,
    input  cnt_en, cnt_clr, adj_sec, adj_min, paused, blink
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stopwatch_ctrl : input conditioning, tick divider and RUN/PAUSED/ADJUST FSM
// Rev 1.0
// ----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int CLK_DIV_1HZ = 100_000_000,
  parameter int DEB_LEN     = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  stopwatch_ctrl_if.master  bus
);
  localparam int DIV_W = $clog2(CLK_DIV_1HZ);
  localparam int DEB_W = $clog2(DEB_LEN);
  localparam int N_IN  = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_1HZ - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV_1HZ / 2 - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_LEN - 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_PAUSED = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;

  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] deb;
  logic [N_IN-1:0] deb_d;

  assign raw = {bus.sw_sel, bus.sw_adj, bus.btn_clr, bus.btn_pause};

  // Counter tracks consecutive cycles where the synced input disagrees with the debounced level
  generate
    for (genvar i = 0; i < N_IN; i++) begin : g_cond
      logic [1:0]       sync;
      logic [DEB_W-1:0] cnt;
      logic             lvl;
      logic             lvl_d;

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync  <= 2'b00;
          cnt   <= '0;
          lvl   <= 1'b0;
          lvl_d <= 1'b0;
        end else begin
          sync  <= {sync[0], raw[i]};
          lvl_d <= lvl;
          if (sync[1] == lvl) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt <= '0;
            lvl <= sync[1];
          end else begin
            cnt <= cnt + DEB_W'(1);
          end
        end
      end

      assign deb[i]   = lvl;
      assign deb_d[i] = lvl_d;
    end
  endgenerate

  logic pause_p, clr_p, adj, sel;
  assign pause_p = deb[0] & ~deb_d[0];
  assign clr_p   = deb[1] & ~deb_d[1];
  assign adj     = deb[2];
  assign sel     = deb[3];

  logic [DIV_W-1:0] div;
  logic             tick1, tick2;

  always_ff @(posedge clk) begin
    if (!rst)                div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                     div <= div + DIV_W'(1);
  end

  assign tick1 = (div == DIV_LAST);
  assign tick2 = tick1 | (div == DIV_HALF);

  logic [1:0] state, state_nx;
  logic [1:0] ret, ret_nx;
  logic       cnt_en_nx, cnt_clr_nx, adj_sec_nx, adj_min_nx, paused_nx, blink_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      ret         <= ST_RUN;
      bus.cnt_en  <= 1'b0;
      bus.cnt_clr <= 1'b0;
      bus.adj_sec <= 1'b0;
      bus.adj_min <= 1'b0;
      bus.paused  <= 1'b0;
      bus.blink   <= 1'b1;
    end else begin
      state       <= state_nx;
      ret         <= ret_nx;
      bus.cnt_en  <= cnt_en_nx;
      bus.cnt_clr <= cnt_clr_nx;
      bus.adj_sec <= adj_sec_nx;
      bus.adj_min <= adj_min_nx;
      bus.paused  <= paused_nx;
      bus.blink   <= blink_nx;
    end
  end

  // The adjust switch takes priority over a coincident pause pulse
  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    case (state)
      ST_RUN: begin
        if (adj) begin
          state_nx = ST_ADJUST;
          ret_nx   = ST_RUN;
        end else if (pause_p) begin
          state_nx = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (adj) begin
          state_nx = ST_ADJUST;
          ret_nx   = ST_PAUSED;
        end else if (pause_p) begin
          state_nx = ST_RUN;
        end
      end
      ST_ADJUST: begin
        if (!adj) state_nx = ret;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_en_nx  = ((state == ST_RUN) & tick1 | (state == ST_ADJUST) & tick2) & ~clr_p;
    cnt_clr_nx = clr_p;
    adj_sec_nx = (state_nx == ST_ADJUST) & ~sel;
    adj_min_nx = (state_nx == ST_ADJUST) & sel;
    paused_nx  = (state_nx == ST_PAUSED);
    if (state_nx != ST_ADJUST || state != ST_ADJUST) blink_nx = 1'b1;
    else if (tick2)                                  blink_nx = ~bus.blink;
    else                                             blink_nx = bus.blink;
  end
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stopwatch_ctrl : directed + random stimulus against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stopwatch_ctrl;
  localparam int CDIV = 10;
  localparam int DEB  = 4;
  localparam int S_RUN = 0, S_PAUSED = 1, S_ADJ = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stopwatch_ctrl_if sw_if();

  stopwatch_ctrl #(.CLK_DIV_1HZ(CDIV), .DEB_LEN(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: debounced level = flips once the last DEB synced samples all disagree with it
  bit hist [4][DEB+2];
  bit m_deb [4];
  bit m_rose [4];
  int m_state, m_ret, m_div, m_blinks, cyc;
  bit e_cnt_en, e_cnt_clr, e_adj_sec, e_adj_min, e_paused, e_blink;

  task automatic model_step();
    bit raw_now [4];
    bit t1, t2, adj, sel, pp, cp, all_opp;
    int nst, nret;
    raw_now[0] = sw_if.btn_pause;
    raw_now[1] = sw_if.btn_clr;
    raw_now[2] = sw_if.sw_adj;
    raw_now[3] = sw_if.sw_sel;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < DEB + 2; j++) hist[i][j] = 1'b0;
        m_deb[i]  = 1'b0;
        m_rose[i] = 1'b0;
      end
      m_state = S_RUN; m_ret = S_RUN; m_div = 0; m_blinks = 0; cyc = 0;
      e_cnt_en = 0; e_cnt_clr = 0; e_adj_sec = 0; e_adj_min = 0; e_paused = 0; e_blink = 1;
    end else begin
      cyc++;
      t1  = (m_div == CDIV - 1);
      t2  = t1 || (m_div == CDIV / 2 - 1);
      pp  = m_rose[0];
      cp  = m_rose[1];
      adj = m_deb[2];
      sel = m_deb[3];
      nst = m_state; nret = m_ret;
      if (m_state == S_ADJ) begin
        if (!adj) nst = m_ret;
      end else if (adj) begin
        nst = S_ADJ; nret = m_state;
      end else if (pp) begin
        nst = (m_state == S_RUN) ? S_PAUSED : S_RUN;
      end
      e_cnt_en  = ((m_state == S_RUN && t1) || (m_state == S_ADJ && t2)) && !cp;
      e_cnt_clr = cp;
      e_adj_sec = (nst == S_ADJ) && !sel;
      e_adj_min = (nst == S_ADJ) && sel;
      e_paused  = (nst == S_PAUSED);
      if (nst == S_ADJ && m_state == S_ADJ) begin
        if (t2) m_blinks++;
      end else begin
        m_blinks = 0;
      end
      e_blink = (m_blinks % 2) == 0;
      for (int i = 0; i < 4; i++) begin
        all_opp = 1'b1;
        for (int j = 1; j <= DEB; j++) if (hist[i][j] == m_deb[i]) all_opp = 1'b0;
        m_rose[i] = all_opp && !m_deb[i];
        if (all_opp) m_deb[i] = !m_deb[i];
        for (int j = DEB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = raw_now[i];
      end
      m_div   = (m_div + 1) % CDIV;
      m_state = nst;
      m_ret   = nret;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("cnt_en",  sw_if.cnt_en,  e_cnt_en);
      chk("cnt_clr", sw_if.cnt_clr, e_cnt_clr);
      chk("adj_sec", sw_if.adj_sec, e_adj_sec);
      chk("adj_min", sw_if.adj_min, e_adj_min);
      chk("paused",  sw_if.paused,  e_paused);
      chk("blink",   sw_if.blink,   e_blink);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic press_pause();
    sw_if.btn_pause = 1'b1;
    repeat (6) @(negedge clk);
    sw_if.btn_pause = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int   hits[$];
    int   ntrans, nen, ntog, first;
    bit   seen, prev;
    logic [5:0] pat;
    sw_if.btn_pause = 0; sw_if.btn_clr = 0; sw_if.sw_adj = 0; sw_if.sw_sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_blink", sw_if.blink, 1);
    chk("rst_paused", sw_if.paused, 0);
    rst = 1'b1;

    // Free-running divider: strobes one clk after div==9
    seen = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (sw_if.cnt_en) hits.push_back(k);
      if (sw_if.paused) seen = 1;
    end
    chk("t1_en_count", hits.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_en_at", (i < hits.size()) ? hits[i] : -1, 10 * (i + 1));
    chk("t1_paused", seen, 0);

    // Glitchy press: 1,0,1,1,1,1
    pat = 6'b111101;
    ntrans = 0; prev = sw_if.paused;
    for (int k = 0; k < 6; k++) begin
      sw_if.btn_pause = pat[k];
      @(negedge clk);
      if (sw_if.paused != prev) ntrans++;
      prev = sw_if.paused;
    end
    sw_if.btn_pause = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sw_if.paused != prev) ntrans++;
      prev = sw_if.paused;
    end
    nen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (sw_if.cnt_en) nen++;
      if (sw_if.paused != prev) ntrans++;
      prev = sw_if.paused;
    end
    chk("t2_paused", sw_if.paused, 1);
    chk("t2_transitions", ntrans, 1);
    chk("t2_no_en_paused", nen, 0);
    press_pause();
    chk("t2_resume", sw_if.paused, 0);

    // Adjust entered from PAUSED returns to PAUSED
    press_pause();
    sw_if.sw_adj = 1'b1; sw_if.sw_sel = 1'b1;
    repeat (12) @(negedge clk);
    chk("t3_adj_min", sw_if.adj_min, 1);
    chk("t3_adj_sec", sw_if.adj_sec, 0);
    chk("t3_paused", sw_if.paused, 0);
    nen = 0; ntog = 0; prev = sw_if.blink;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sw_if.cnt_en) nen++;
      if (sw_if.blink != prev) ntog++;
      prev = sw_if.blink;
    end
    chk("t3_en_count", nen, 4);
    chk("t3_blink_toggles", ntog, 4);
    sw_if.sw_adj = 1'b0; sw_if.sw_sel = 1'b0;
    repeat (12) @(negedge clk);
    chk("t3_ret_paused", sw_if.paused, 1);
    chk("t3_adj_off", sw_if.adj_min, 0);
    press_pause();

    // Clear pulse lands on a tick1 cycle in RUN
    do @(negedge clk); while (cyc % 10 != 3);
    sw_if.btn_clr = 1'b1;
    repeat (7) @(negedge clk);
    chk("t4_clr", sw_if.cnt_clr, 1);
    chk("t4_en_forced0", sw_if.cnt_en, 0);
    chk("t4_state_run", sw_if.paused, 0);
    @(negedge clk);
    chk("t4_clr_width", sw_if.cnt_clr, 0);
    sw_if.btn_clr = 1'b0;
    repeat (10) @(negedge clk);

    // Pause ignored in ADJUST
    sw_if.sw_adj = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_adj_sec", sw_if.adj_sec, 1);
    press_pause();
    chk("t5_paused", sw_if.paused, 0);
    chk("t5_adj_sec_kept", sw_if.adj_sec, 1);
    chk("t5_adj_min_kept", sw_if.adj_min, 0);

    // Reset mid-ADJUST, switch still held
    rst = 1'b0;
    @(negedge clk);
    chk("t6_cnt_en", sw_if.cnt_en, 0);
    chk("t6_cnt_clr", sw_if.cnt_clr, 0);
    chk("t6_adj_sec", sw_if.adj_sec, 0);
    chk("t6_adj_min", sw_if.adj_min, 0);
    chk("t6_paused", sw_if.paused, 0);
    chk("t6_blink", sw_if.blink, 1);
    rst = 1'b1;
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if ((sw_if.adj_sec || sw_if.adj_min) && first < 0) first = k;
    end
    chk("t6_reentry_cycle", first, 7);
    sw_if.sw_adj = 1'b0;
    repeat (12) @(negedge clk);

    // Random phase, checked every cycle by the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7)  == 0) sw_if.btn_pause = ~sw_if.btn_pause;
      if ($urandom_range(0, 8)  == 0) sw_if.btn_clr   = ~sw_if.btn_clr;
      if ($urandom_range(0, 39) == 0) sw_if.sw_adj    = ~sw_if.sw_adj;
      if ($urandom_range(0, 14) == 0) sw_if.sw_sel    = ~sw_if.sw_sel;
      rst = ($urandom_range(0, 299) != 0);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
